vlc_frame_tx: RTL and testbench

- Parametrised next-generation VLC bit-serial transmitter.
- Pulls DATA_W-bit words from a standard (non-FWFT) FIFO and emits framed on-off-keyed bits on tx at pclk/CLK_DIV.
- Frame: sync preamble (high then low), WORDS_PER_FRAME words MSB-first, then a low guard gap.
- Adds over the previous generation: word prefetch with a next-word register, early frame termination on underrun, frame_done/underrun status, and optional Manchester coding. Drives the LED driver stage.

---
 rtl/vlc_tx_pkg.sv | 28 ++
 rtl/vlc_baud_gen.sv | 40 ++++
 rtl/vlc_frame_tx.sv | 217 +++++++++++++++++++++
 tb/tb_vlc_frame_tx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vlc_tx_pkg.sv
// Shared types, constants and helpers for the VLC frame transmitter.
// MANCHESTER_EN selects Manchester coding of the data bits in the users of this package.
package vlc_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SYNC,
    SEND,
    GAP
  } state_t;

  // First half of a Manchester bit is data ^ MANCH_POL, second half its inverse.
  localparam logic MANCH_POL = 1'b0;

  function automatic int cntWidth(input int limit);
    return (limit <= 2) ? 1 : $clog2(limit);
  endfunction

  function automatic bit paramsLegal(input int dataW, input int clkDiv,
                                     input int syncHi, input int syncLo,
                                     input int words, input int gapBits,
                                     input bit manchester);
    return (dataW >= 2) && (clkDiv >= 2) && (syncHi >= 1) && (syncLo >= 1) &&
           (words >= 1) && (gapBits >= 1) && (!manchester || (clkDiv % 2 == 0));
  endfunction

endpackage

// File: rtl/vlc_baud_gen.sv
// Bit-period tick generator; counter is parked at zero while i_hold is high.
// With MANCHESTER_EN defined it also flags the mid-bit half-tick.
module vlc_baud_gen
  import vlc_tx_pkg::*;
#(
  parameter int CLK_DIV = 50
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_hold,
  output logic o_tick
`ifdef MANCHESTER_EN
  , output logic o_halfTick
`endif
);

  localparam int CW = cntWidth(CLK_DIV);

  logic [CW-1:0] r_cnt;
  logic          w_atEnd;

  assign w_atEnd = (r_cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_cnt <= '0;
    end else if (i_hold || w_atEnd) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = !i_hold && w_atEnd;

`ifdef MANCHESTER_EN
  assign o_halfTick = !i_hold && (r_cnt == CW'(CLK_DIV / 2 - 1));
`endif

endmodule

// File: rtl/vlc_frame_tx.sv
// Framed OOK bit-serial VLC transmitter fed from a standard (non-FWFT) FIFO.
// Define MANCHESTER_EN to Manchester-code the data bits; preamble and gap stay NRZ.
module vlc_frame_tx
  import vlc_tx_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int CLK_DIV         = 50,
  parameter int SYNC_HI         = 5,
  parameter int SYNC_LO         = 5,
  parameter int WORDS_PER_FRAME = 9,
  parameter int GAP_BITS        = 12
) (
  input  logic              pclk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun
);

`ifdef MANCHESTER_EN
  localparam bit MANCH = 1'b1;
`else
  localparam bit MANCH = 1'b0;
`endif

  localparam int SYNC_W = cntWidth(SYNC_HI + SYNC_LO);
  localparam int IDX_W  = cntWidth(DATA_W);
  localparam int WRD_W  = cntWidth(WORDS_PER_FRAME);
  localparam int GAP_W  = cntWidth(GAP_BITS);

  if (!paramsLegal(DATA_W, CLK_DIV, SYNC_HI, SYNC_LO, WORDS_PER_FRAME, GAP_BITS, MANCH)) begin : gIllegal
    $error("vlc_frame_tx: illegal parameter set");
  end

  state_t              r_state;
  logic [DATA_W-1:0]   r_curWord;
  logic [DATA_W-1:0]   r_nextWord;
  logic                r_nextValid;
  logic                r_rdPend;
  logic [SYNC_W-1:0]   r_syncCnt;
  logic [IDX_W-1:0]    r_bitIdx;
  logic [WRD_W-1:0]    r_wordsSent;
  logic [GAP_W-1:0]    r_gapCnt;
  logic                r_rdEn;
  logic                r_tx;
  logic                r_busy;
  logic                r_frameDone;
  logic                r_underrun;

  logic                w_hold;
  logic                w_tick;
  logic                w_lastBit;
  logic                w_lastWord;
  logic                w_avail;
  logic [DATA_W-1:0]   w_nextData;
  logic                w_prefetch;
`ifdef MANCHESTER_EN
  logic                w_halfTick;
`endif

  assign w_hold = (r_state == IDLE) || (r_state == LOAD);

  vlc_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .i_clk      (pclk),
    .i_rstn     (rstn),
    .i_hold     (w_hold),
    .o_tick     (w_tick)
`ifdef MANCHESTER_EN
    , .o_halfTick (w_halfTick)
`endif
  );

  // Level driven during the first half (or the whole, for NRZ) of a data bit.
  function automatic logic firstHalf(input logic b);
`ifdef MANCHESTER_EN
    return b ^ MANCH_POL;
`else
    return b;
`endif
  endfunction

  assign w_lastBit  = (r_bitIdx == IDX_W'(DATA_W - 1));
  assign w_lastWord = (r_wordsSent == WRD_W'(WORDS_PER_FRAME - 1));

  // A read landing in the same cycle as the word boundary is forwarded straight from the FIFO.
  assign w_avail    = r_nextValid || r_rdPend;
  assign w_nextData = r_nextValid ? r_nextWord : fifo_dout;

  assign w_prefetch = (r_state == SEND) && w_tick && !w_lastBit &&
                      (r_wordsSent < WRD_W'(WORDS_PER_FRAME - 1)) &&
                      !r_nextValid && !r_rdPend && !r_rdEn && !fifo_empty;

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_curWord   <= '0;
      r_nextWord  <= '0;
      r_nextValid <= 1'b0;
      r_rdPend    <= 1'b0;
      r_syncCnt   <= '0;
      r_bitIdx    <= '0;
      r_wordsSent <= '0;
      r_gapCnt    <= '0;
      r_rdEn      <= 1'b0;
      r_tx        <= 1'b0;
      r_busy      <= 1'b0;
      r_frameDone <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_rdEn      <= 1'b0;
      r_frameDone <= 1'b0;
      r_underrun  <= 1'b0;
      r_rdPend    <= r_rdEn;

      if (r_rdPend && (r_state == SEND) && !(w_tick && w_lastBit)) begin
        r_nextWord  <= fifo_dout;
        r_nextValid <= 1'b1;
      end

      unique case (r_state)
        IDLE: begin
          if (!fifo_empty) begin
            r_rdEn  <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end

        LOAD: begin
          if (r_rdPend) begin
            r_curWord <= fifo_dout;
            r_syncCnt <= '0;
            r_tx      <= 1'b1;
            r_state   <= SYNC;
          end
        end

        SYNC: begin
          if (w_tick) begin
            if (r_syncCnt == SYNC_W'(SYNC_HI + SYNC_LO - 1)) begin
              r_bitIdx    <= '0;
              r_wordsSent <= '0;
              r_tx        <= firstHalf(r_curWord[DATA_W-1]);
              r_state     <= SEND;
            end else begin
              r_syncCnt <= r_syncCnt + SYNC_W'(1);
              if (r_syncCnt == SYNC_W'(SYNC_HI - 1)) begin
                r_tx <= 1'b0;
              end
            end
          end
        end

        SEND: begin
          if (w_prefetch) begin
            r_rdEn <= 1'b1;
          end
          if (w_tick) begin
            if (!w_lastBit) begin
              r_curWord <= r_curWord << 1;
              r_tx      <= firstHalf(r_curWord[DATA_W-2]);
              r_bitIdx  <= r_bitIdx + IDX_W'(1);
            end else if (!w_lastWord && w_avail) begin
              r_curWord   <= w_nextData;
              r_nextValid <= 1'b0;
              r_tx        <= firstHalf(w_nextData[DATA_W-1]);
              r_bitIdx    <= '0;
              r_wordsSent <= r_wordsSent + WRD_W'(1);
            end else begin
              r_underrun  <= !w_lastWord;
              r_nextValid <= 1'b0;
              r_gapCnt    <= '0;
              r_tx        <= 1'b0;
              r_state     <= GAP;
            end
          end
`ifdef MANCHESTER_EN
          else if (w_halfTick) begin
            r_tx <= ~firstHalf(r_curWord[DATA_W-1]);
          end
`endif
        end

        GAP: begin
          if (w_tick) begin
            if (r_gapCnt == GAP_W'(GAP_BITS - 1)) begin
              r_gapCnt    <= '0;
              r_frameDone <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= IDLE;
            end else begin
              r_gapCnt <= r_gapCnt + GAP_W'(1);
            end
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd_en = r_rdEn;
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_frameDone;
  assign underrun   = r_underrun;

endmodule

// File: tb/tb_vlc_frame_tx.sv
// Self-checking bench for vlc_frame_tx: table vectors, hand-written corner sequences and
// random frames compared against a per-pclk expected tx waveform built from the frame rules.
module tb_vlc_frame_tx;

  localparam int DW   = 8;
  localparam int DIV  = 4;
  localparam int SHI  = 2;
  localparam int SLO  = 2;
  localparam int WPF  = 2;
  localparam int GAPB = 3;

  logic          pclk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic          tx;
  logic          busy;
  logic          frame_done;
  logic          underrun;

  always #5 pclk = ~pclk;

  vlc_frame_tx #(
    .DATA_W          (DW),
    .CLK_DIV         (DIV),
    .SYNC_HI         (SHI),
    .SYNC_LO         (SLO),
    .WORDS_PER_FRAME (WPF),
    .GAP_BITS        (GAPB)
  ) dut (
    .pclk       (pclk),
    .rstn       (rstn),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  logic [DW-1:0] fifoMem [256];
  int            wrPtr = 0;
  int            rdPtr = 0;
  int            cyc = 0;
  int            rdCount = 0;
  int            underrunCount = 0;
  int            emptyViol = 0;
  int            testCount = 0;
  int            failCount = 0;
  logic          expTx [$];

  assign fifo_empty = (wrPtr == rdPtr);

  // Standard FIFO: data appears the cycle after the read strobe.
  always @(posedge pclk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_dout <= fifoMem[rdPtr % 256];
      rdPtr     <= rdPtr + 1;
    end
  end

  // Event counters, sampled with the values held during the cycle just ending.
  always @(posedge pclk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) rdCount <= rdCount + 1;
    if (underrun) underrunCount <= underrunCount + 1;
    if (fifo_rd_en && fifo_empty) emptyViol <= emptyViol + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic pushWord(input logic [DW-1:0] w);
    fifoMem[wrPtr % 256] = w;
    wrPtr = wrPtr + 1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    testCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Expected tx level for every pclk from the first SYNC cycle to the last GAP cycle.
  task automatic buildExpected(input logic [DW-1:0] w0, input logic [DW-1:0] w1, input int nWords);
    logic [DW-1:0] w;
    expTx.delete();
    repeat (SHI * DIV) expTx.push_back(1'b1);
    repeat (SLO * DIV) expTx.push_back(1'b0);
    for (int k = 0; k < nWords; k++) begin
      w = (k == 0) ? w0 : w1;
      for (int b = DW - 1; b >= 0; b--) begin
`ifdef MANCHESTER_EN
        repeat (DIV / 2) expTx.push_back(w[b]);
        repeat (DIV / 2) expTx.push_back(~w[b]);
`else
        repeat (DIV) expTx.push_back(w[b]);
`endif
      end
    end
    repeat (GAPB * DIV) expTx.push_back(1'b0);
  endtask

  // Runs one frame: optional pushes, then checks latency, tx waveform, frame_done and counts.
  task automatic applyStimulus(input string tag, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                               input int nPush, input int nFrame, input int lateAt,
                               input int expUnder, input int expReads);
    int rdBase;
    int undBase;
    int rdCyc;
    int txCyc;
    int errs;
    int earlyDone;
    int waitN;
    rdBase  = rdCount;
    undBase = underrunCount;
    if (nPush > 0) begin
      @(negedge pclk);
      pushWord(w0);
      if (nPush > 1 && lateAt < 0) pushWord(w1);
    end
    waitN = 0;
    while (!fifo_rd_en && waitN < 50) begin
      @(negedge pclk);
      waitN++;
    end
    if (!fifo_rd_en) begin
      checkOutput({tag, " read start timeout"}, 0, 1);
      return;
    end
    rdCyc = cyc;
    waitN = 0;
    while (!tx && waitN < 50) begin
      @(negedge pclk);
      waitN++;
    end
    if (!tx) begin
      checkOutput({tag, " tx rise timeout"}, 0, 1);
      return;
    end
    txCyc = cyc;
    checkOutput({tag, " read-to-tx latency"}, txCyc - rdCyc, 2);
    buildExpected(w0, w1, nFrame);
    errs = 0;
    earlyDone = 0;
    for (int i = 0; i < expTx.size(); i++) begin
      if (i > 0) @(negedge pclk);
      if (i == lateAt) pushWord(w1);
      if (tx !== expTx[i]) errs++;
      if (frame_done) earlyDone++;
    end
    @(negedge pclk);
    checkOutput({tag, " tx stream mismatching cycles"}, errs, 0);
    checkOutput({tag, " early frame_done"}, earlyDone, 0);
    checkOutput({tag, " frame_done at frame end"}, int'(frame_done), 1);
    checkOutput({tag, " busy after frame"}, int'(busy), 0);
    checkOutput({tag, " fifo reads"}, rdCount - rdBase, expReads);
    checkOutput({tag, " underrun pulses"}, underrunCount - undBase, expUnder);
  endtask

  typedef struct {
    logic [DW-1:0] w0;
    logic [DW-1:0] w1;
    int            nWords;
    int            expReads;
    int            expUnder;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int            rdBase;
    int            n;
    logic [DW-1:0] r0;
    logic [DW-1:0] r1;

    vecs[0] = '{w0: 8'hA5, w1: 8'h3C, nWords: 2, expReads: 2, expUnder: 0};
    vecs[1] = '{w0: 8'hFF, w1: 8'h00, nWords: 1, expReads: 1, expUnder: 1};
    vecs[2] = '{w0: 8'h00, w1: 8'hFF, nWords: 2, expReads: 2, expUnder: 0};
    vecs[3] = '{w0: 8'h80, w1: 8'h01, nWords: 2, expReads: 2, expUnder: 0};

    repeat (3) @(negedge pclk);
    checkOutput("reset tx", int'(tx), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset fifo_rd_en", int'(fifo_rd_en), 0);
    checkOutput("reset frame_done", int'(frame_done), 0);
    checkOutput("reset underrun", int'(underrun), 0);
    rstn = 1'b1;
    repeat (5) @(negedge pclk);
    checkOutput("idle with empty fifo busy", int'(busy), 0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].w0, vecs[i].w1, vecs[i].nWords,
                    vecs[i].nWords, -1, vecs[i].expUnder, vecs[i].expReads);
      repeat (2) @(negedge pclk);
    end

    // Second word arrives at the start of data bit 6 of the first word.
    applyStimulus("late word", 8'hC3, 8'h5A, 2, 2, (SHI + SLO + 6) * DIV, 0, 2);
    repeat (2) @(negedge pclk);

    // Four words queued: two frames with a single IDLE cycle between them.
    @(negedge pclk);
    pushWord(8'h11);
    pushWord(8'h22);
    pushWord(8'h33);
    pushWord(8'h44);
    applyStimulus("b2b frame1", 8'h11, 8'h22, 0, 2, -1, 0, 2);
    checkOutput("b2b rd_en in frame_done cycle", int'(fifo_rd_en), 0);
    @(negedge pclk);
    checkOutput("b2b rd_en after frame_done", int'(fifo_rd_en), 1);
    applyStimulus("b2b frame2", 8'h33, 8'h44, 0, 2, -1, 0, 2);
    repeat (2) @(negedge pclk);

    // Asynchronous reset in the middle of data bit 5.
    @(negedge pclk);
    pushWord(8'hA5);
    pushWord(8'h3C);
    n = 0;
    while (!tx && n < 50) begin
      @(negedge pclk);
      n++;
    end
    checkOutput("rst seq tx rise seen", int'(tx), 1);
    repeat ((SHI + SLO + 5) * DIV + 1) @(negedge pclk);
    checkOutput("rst seq tx before reset", int'(tx), 1);
    checkOutput("rst seq busy before reset", int'(busy), 1);
    #1 rstn = 1'b0;
    #1;
    checkOutput("async reset tx", int'(tx), 0);
    checkOutput("async reset busy", int'(busy), 0);
    checkOutput("async reset fifo_rd_en", int'(fifo_rd_en), 0);
    @(negedge pclk);
    rstn = 1'b1;
    rdBase = rdCount;
    repeat (20) @(negedge pclk);
    checkOutput("post reset busy", int'(busy), 0);
    checkOutput("post reset tx", int'(tx), 0);
    checkOutput("post reset reads", rdCount - rdBase, 0);

    for (int i = 0; i < 6; i++) begin
      n  = int'($urandom_range(1, 2));
      r0 = DW'($urandom);
      r1 = DW'($urandom);
      applyStimulus($sformatf("rand%0d", i), r0, r1, n, n, -1, (n < WPF) ? 1 : 0, n);
      repeat (1 + int'($urandom_range(0, 3))) @(negedge pclk);
    end

    checkOutput("fifo_rd_en while empty", emptyViol, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
